cacheline_adapter: RTL and testbench

//  Downstream neighbour of the 2-way cache: sits between the cache's memory-side controller port and main memory.

---
 rtl/cacheline_adapter.sv | 119 +++++++++++
 tb/tb_cacheline_adapter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: moves one cache line to/from memory as an aligned burst of LINE_W/BURST_W beats.
// Define ADAPTER_TIMEOUT_EN to abort a stalled burst after TIMEOUT_CYCLES idle memory cycles (error_o flags it).
module cacheline_adapter #(
    parameter int LINE_W         = 256,
    parameter int BURST_W        = 64,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    output logic               error_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int OFF = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN = {ADDR_W{1'b1}} << OFF;

    if (LINE_W % BURST_W != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cacheline_adapter: invalid parameters");
    end

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              timeout;

`ifdef ADAPTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q, idle_d;
    logic          err_q, err_d;
    logic          busy;

    assign busy    = state_q == RD_BURST || state_q == WR_BURST;
    assign timeout = busy && !resp_i && idle_q == TW'(TIMEOUT_CYCLES - 1);
    assign error_o = err_q;

    // Counter sits at zero outside bursts, so every burst starts with a fresh budget.
    always_comb begin
        idle_d = (busy && !resp_i && !timeout) ? idle_q + 1'b1 : '0;
        err_d  = timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign error_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        line_d  = line_q;
        case (state_q)
            IDLE: if (read_i || write_i) begin
                addr_d  = address_i & ALIGN;
                cnt_d   = '0;
                wline_d = write_i ? line_i : wline_q;
                state_d = write_i ? WR_BURST : RD_BURST;
            end
            RD_BURST, WR_BURST: if (timeout) begin
                state_d = DONE;
            end else if (resp_i) begin
                if (state_q == RD_BURST) line_d[cnt_q*BURST_W +: BURST_W] = burst_i;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(BEATS - 1) ? DONE : state_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            line_q  <= line_d;
        end
    end

    assign read_o    = state_q == RD_BURST;
    assign write_o   = state_q == WR_BURST;
    assign resp_o    = state_q == DONE;
    assign address_o = addr_q;
    assign line_o    = line_q;
    assign burst_o   = wline_q[cnt_q*BURST_W +: BURST_W];
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: randomized line transfers against a transaction-level model of the adapter.
module tb_cacheline_adapter;
    localparam int LW = 256, BW = 64, AW = 32, BEATS = LW / BW;

    logic          clk = 1'b0, rst = 1'b1;
    logic [LW-1:0] line_i = '0, line_o;
    logic [AW-1:0] address_i = '0, address_o;
    logic          read_i = 1'b0, write_i = 1'b0, resp_o, error_o;
    logic [BW-1:0] burst_i = '0, burst_o;
    logic          read_o, write_o, resp_i = 1'b0;

    int            checks = 0, errors = 0;
    logic [LW-1:0] exp_line = '0;

    always #5 clk = ~clk;

    cacheline_adapter #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
        .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .error_o(error_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // mode 0: zero-wait memory, 1: random waits, 2: three waits before beat 2
    task automatic xfer(input bit wr, input bit rd, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wl, input logic [LW-1:0] rl, input int mode);
        logic [AW-1:0] exp_addr;
        int k, waits, cyc, stall;
        bit go;
        exp_addr = addr & ~32'h1F;
        k = 0;
        waits = 0;
        stall = 0;
        address_i = addr;
        line_i = wl;
        write_i = wr;
        read_i = rd;
        resp_i = 1'b0;
        tick;
        address_i = $urandom;
        line_i = rand_line();
        for (cyc = 1; cyc < 200; cyc++) begin
            check("resp_o", resp_o, k == BEATS);
            check("error_o", error_o, 0);
            check("read_o", read_o, !wr && k < BEATS);
            check("write_o", write_o, wr && k < BEATS);
            if (k == BEATS) break;
            check("address_o", address_o, exp_addr);
            if (wr) check("burst_o", burst_o, wl[k*BW +: BW]);
            go = mode == 0 ? 1'b1 : mode == 2 ? !(k == 2 && stall < 3) : $urandom_range(0, 2) != 0;
            if (!go) begin
                stall++;
                waits++;
            end
            resp_i = go;
            burst_i = go ? rl[k*BW +: BW] : {$urandom, $urandom};
            if (go) k++;
            tick;
        end
        check("beats", k, BEATS);
        check("latency", cyc, BEATS + waits + 1);
        if (!wr) exp_line = rl;
        check("line_o", line_o, exp_line);
        read_i = 1'b0;
        write_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_i = $urandom;
            tick;
            check("idle_resp_o", resp_o, 0);
            check("idle_req", {read_o, write_o}, 0);
        end
        resp_i = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] l;
        bit wr, rd;
        int hi, errs;
        tick;
        tick;
        rst = 1'b0;
        check("rst_resp", resp_o, 0);
        check("rst_req", {read_o, write_o, error_o}, 0);
        check("rst_addr", address_o, 0);
        check("rst_line", line_o, 0);
        check("rst_burst", burst_o, 0);

        xfer(0, 1, 32'h0000_1234, rand_line(),
             {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111}, 0);
        xfer(1, 0, 32'h8000_0040, {4{64'h0123456789ABCDEF}}, rand_line(), 0);
        xfer(0, 1, $urandom, rand_line(), rand_line(), 2);
        xfer(1, 1, $urandom, rand_line(), rand_line(), 1);

        // reset in the middle of a read burst
        read_i = 1'b1;
        address_i = 32'h0000_5678;
        tick;
        resp_i = 1'b1;
        burst_i = {$urandom, $urandom};
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        read_i = 1'b0;
        resp_i = 1'b0;
        exp_line = '0;
        check("mid_rst_req", {read_o, write_o, resp_o, error_o}, 0);
        check("mid_rst_addr", address_o, 0);
        check("mid_rst_line", line_o, 0);
        tick;
        check("mid_rst_resp", resp_o, 0);
        xfer(0, 1, $urandom, rand_line(), rand_line(), 0);

        // memory never answers
        read_i = 1'b1;
        address_i = $urandom;
        tick;
        hi = 0;
        errs = 0;
`ifdef ADAPTER_TIMEOUT_EN
        for (int i = 1; i < 30 && !resp_o; i++) begin
            hi += read_o;
            tick;
        end
        check("to_waits", hi, 8);
        check("to_resp", {resp_o, error_o, read_o}, 3'b110);
        read_i = 1'b0;
        tick;
        check("to_after", {resp_o, error_o}, 0);
`else
        for (int i = 0; i < 300; i++) begin
            hi += read_o;
            errs += error_o | resp_o;
            tick;
        end
        check("stall_read_o", hi, 300);
        check("stall_err", errs, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        read_i = 1'b0;
`endif
        exp_line = '0;
        tick;

        for (int n = 0; n < 30; n++) begin
            wr = $urandom;
            rd = wr ? 1'($urandom) : 1'b1;
            l = rand_line();
            xfer(wr, rd, $urandom, l, rand_line(), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
